// File: rtl/sram_pkg.sv
// ----------------------------------------------------------------------------
// sram_pkg
//   Shared definitions for the Nexys2 asynchronous-SRAM port controller:
//   controller state encoding, default strobe widths, byte-enable constants
//   and a small elaboration-time helper.
// ----------------------------------------------------------------------------
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD      = 2'd1,
        WR      = 2'd2,
        WR_HOLD = 2'd3
    } state_t;

    localparam int RD_WAIT_DEF = 2;
    localparam int WR_WAIT_DEF = 2;

    // Byte-enable encodings: bit 1 = upper byte, bit 0 = lower byte.
    localparam logic [1:0] BE_LO  = 2'b01;
    localparam logic [1:0] BE_HI  = 2'b10;
    localparam logic [1:0] BE_ALL = 2'b11;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sram_port_ctrl.sv
// ----------------------------------------------------------------------------
// sram_port_ctrl
//   Single-word port controller for an external asynchronous SRAM. A request
//   (mem=1 while ready=1) captures address, write data and byte enables, then
//   runs a fixed-length read or write strobe sequence on the SRAM pins.
//   Every pin output is registered so the SRAM sees glitch-free strobes.
//
// Parameters
//   ADDR_W   SRAM word-address width
//   DATA_W   data bus width (two byte lanes)
//   RD_WAIT  cycles oe_n is low before read data is sampled (>= 1)
//   WR_WAIT  cycles we_n is low (>= 1)
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   mem, rw             request strobe, 1 = read / 0 = write
//   addr, data_f2s, be  word address, write data, byte enables
//   ready               idle, a request may be issued
//   valid               one-cycle pulse when data_s2f_r is updated by a read
//   data_s2f_r          registered read data
//   ad                  SRAM address pins (hold last value when idle)
//   we_n, oe_n, ce_a_n  SRAM strobes, active low
//   ub_a_n, lb_a_n      byte-lane selects, active low
//   dio_a               bidirectional SRAM data bus
// ----------------------------------------------------------------------------
module sram_port_ctrl
    import sram_pkg::*;
#(
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 16,
    parameter int RD_WAIT = RD_WAIT_DEF,
    parameter int WR_WAIT = WR_WAIT_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mem,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_f2s,
    input  logic [1:0]        be,
    output logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data_s2f_r,
    output logic [ADDR_W-1:0] ad,
    output logic              we_n,
    output logic              oe_n,
    output logic              ce_a_n,
    output logic              ub_a_n,
    output logic              lb_a_n,
    inout  wire  [DATA_W-1:0] dio_a
);

    localparam int              CNT_W   = $clog2(max_int(RD_WAIT, WR_WAIT) + 1);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              accept;
    logic              rd_done;

    // Next-cycle pin values; registered below so the pins never glitch.
    logic              ready_d;
    logic              ce_n_d;
    logic              oe_n_d;
    logic              we_n_d;
    logic              ub_n_d;
    logic              lb_n_d;
    logic              drive_d;

    logic              drive_en;
    logic [DATA_W-1:0] wdata;

    // Read/write direction is carried by the state itself, so rw needs no
    // separate holding register.
    assign accept  = (state == IDLE) && mem;
    assign rd_done = (state == RD) && (cnt == CNT_ONE);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. The wait counter loads on state entry and the
    // state is left on the cycle it reads 1.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned,
        // which would otherwise infer a latch.
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (mem) begin
                    if (rw) begin
                        state_next = RD;
                        cnt_next   = RD_LOAD;
                    end else begin
                        state_next = WR;
                        cnt_next   = WR_LOAD;
                    end
                end
            end
            RD: begin
                if (cnt == CNT_ONE) state_next = IDLE;
                else                cnt_next   = cnt - CNT_ONE;
            end
            WR: begin
                if (cnt == CNT_ONE) state_next = WR_HOLD;
                else                cnt_next   = cnt - CNT_ONE;
            end
            WR_HOLD: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode, from the state being entered so the registered pins
    // line up with that state.
    // ------------------------------------------------------------------
    always_comb begin
        ready_d = (state_next == IDLE);
        ce_n_d  = (state_next == IDLE);
        oe_n_d  = (state_next != RD);
        we_n_d  = (state_next != WR);
        drive_d = (state_next == WR) || (state_next == WR_HOLD);
        ub_n_d  = ub_a_n;
        lb_n_d  = lb_a_n;
        if (state_next == IDLE) begin
            ub_n_d = 1'b1;
            lb_n_d = 1'b1;
        end else if (accept) begin
            ub_n_d = ~be[1];
            lb_n_d = ~be[0];
        end
    end

    // ------------------------------------------------------------------
    // Pin, capture and read-data registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready      <= 1'b1;
            valid      <= 1'b0;
            data_s2f_r <= '0;
            ad         <= '0;
            we_n       <= 1'b1;
            oe_n       <= 1'b1;
            ce_a_n     <= 1'b1;
            ub_a_n     <= 1'b1;
            lb_a_n     <= 1'b1;
            drive_en   <= 1'b0;
            wdata      <= '0;
        end else begin
            ready    <= ready_d;
            we_n     <= we_n_d;
            oe_n     <= oe_n_d;
            ce_a_n   <= ce_n_d;
            ub_a_n   <= ub_n_d;
            lb_a_n   <= lb_n_d;
            drive_en <= drive_d;
            valid    <= rd_done;
            if (accept) begin
                ad    <= addr;
                wdata <= data_f2s;
            end
            // All lanes are latched; byte enables only gate the SRAM side.
            if (rd_done) data_s2f_r <= dio_a;
        end
    end

    // The drive enable is registered from the same decode as oe_n, and WR /
    // WR_HOLD never coincide with RD, so the bus is never driven while the
    // SRAM outputs are enabled.
    assign dio_a = drive_en ? wdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_port_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sram_port_ctrl
//   Bench for sram_port_ctrl. A behavioural SRAM device sits on the pins; a
//   transaction-level reference model predicts every pin, cycle by cycle,
//   from the accept edge of the current access. A second instance with
//   RD_WAIT=4 / WR_WAIT=1 is checked against hand-computed values.
// ----------------------------------------------------------------------------
module tb_sram_port_ctrl;
    import sram_pkg::*;

    localparam int         AW   = 18;
    localparam int         DW   = 16;
    localparam int         RDW  = 2;
    localparam int         WRW  = 2;
    localparam int         RDW2 = 4;
    localparam int         WRW2 = 1;
    localparam logic [15:0] PAT2 = 16'h3C5A;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          mem = 1'b0;
    logic          mem2 = 1'b0;
    logic          rw = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] data_f2s = '0;
    logic [1:0]    be = '0;

    logic          ready, valid, we_n, oe_n, ce_a_n, ub_a_n, lb_a_n;
    logic [DW-1:0] data_s2f_r;
    logic [AW-1:0] ad;
    wire  [DW-1:0] dio_a;

    logic          ready2, valid2, we2, oe2, ce2, ub2, lb2;
    logic [DW-1:0] data2;
    logic [AW-1:0] ad2;
    wire  [DW-1:0] dio_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    sram_port_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_WAIT(RDW), .WR_WAIT(WRW)) dut (
        .clk(clk), .reset_n(reset_n), .mem(mem), .rw(rw), .addr(addr),
        .data_f2s(data_f2s), .be(be), .ready(ready), .valid(valid),
        .data_s2f_r(data_s2f_r), .ad(ad), .we_n(we_n), .oe_n(oe_n),
        .ce_a_n(ce_a_n), .ub_a_n(ub_a_n), .lb_a_n(lb_a_n), .dio_a(dio_a)
    );

    sram_port_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_WAIT(RDW2), .WR_WAIT(WRW2)) dut2 (
        .clk(clk), .reset_n(reset_n), .mem(mem2), .rw(rw), .addr(addr),
        .data_f2s(data_f2s), .be(be), .ready(ready2), .valid(valid2),
        .data_s2f_r(data2), .ad(ad2), .we_n(we2), .oe_n(oe2),
        .ce_a_n(ce2), .ub_a_n(ub2), .lb_a_n(lb2), .dio_a(dio_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // A released bus reads as Z, or as 0 where the simulator collapses Z.
    task automatic check_released(input string name, input logic [DW-1:0] bus);
        n_checks++;
        if ($isunknown(bus) || bus == '0) n_pass++;
        else $display("FAIL %s: bus driven with %h, expected released (t=%0t)", name, bus, $time);
    endtask

    // ---------------- behavioural SRAM device (instance 1) ----------------
    logic [15:0] sram_arr [int];
    logic [15:0] sram_rd = '0;
    logic [15:0] sram_w;
    int          we_falls = 0;

    function automatic logic [15:0] sram_word(input int a);
        return sram_arr.exists(a) ? sram_arr[a] : 16'h0000;
    endfunction

    always @(posedge clk) begin
        #1;
        sram_rd = sram_word(int'(ad));
    end

    assign dio_a = (!ce_a_n && !oe_n) ? sram_rd : 16'bz;
    assign dio_b = (!ce2 && !oe2) ? PAT2 : 16'bz;

    always @(posedge we_n) begin
        if (reset_n && !ce_a_n) begin
            sram_w = sram_word(int'(ad));
            if (!ub_a_n) sram_w[15:8] = dio_a[15:8];
            if (!lb_a_n) sram_w[7:0]  = dio_a[7:0];
            sram_arr[int'(ad)] = sram_w;
        end
    end

    always @(negedge we_n) if (reset_n) we_falls++;

    // ---------------- transaction-level reference model -------------------
    logic [15:0]   ref_mem [int];
    bit            m_active = 1'b0;
    bit            m_r;
    int            cyc = 0;
    int            acc_edge = 0;
    bit            acc_rw;
    logic [1:0]    acc_be;
    logic [15:0]   acc_data, acc_rdata, m_w;
    logic [15:0]   exp_rdata = '0;
    logic [AW-1:0] last_ad = '0;

    function automatic logic [15:0] ref_word(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
    endfunction

    // Phase k = 1 is the first cycle after the accepting edge.
    function automatic bit m_ready();
        int k;
        k = cyc - acc_edge + 1;
        if (!m_active) return 1'b1;
        return acc_rw ? (k >= RDW + 1) : (k >= WRW + 2);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_active  = 1'b0;
            exp_rdata = '0;
            last_ad   = '0;
        end else begin
            m_r = m_ready();
            cyc++;
            if (m_active && acc_rw && (cyc - acc_edge + 1 == RDW + 1)) exp_rdata = acc_rdata;
            if (m_r && mem) begin
                m_active = 1'b1;
                acc_edge = cyc;
                acc_rw   = rw;
                acc_be   = be;
                acc_data = data_f2s;
                last_ad  = addr;
                if (rw) begin
                    acc_rdata = ref_word(int'(addr));
                end else begin
                    m_w = ref_word(int'(addr));
                    if (be[1]) m_w[15:8] = data_f2s[15:8];
                    if (be[0]) m_w[7:0]  = data_f2s[7:0];
                    ref_mem[int'(addr)] = m_w;
                end
            end
        end
    end

    // ---------------- per-cycle compare against the model -----------------
    int c_k;
    bit c_rd, c_wr, c_hold, c_busy, c_valid;

    always @(negedge clk) begin
        if (reset_n && cyc > 0) begin
            c_k     = cyc - acc_edge + 1;
            c_rd    = m_active && acc_rw  && (c_k <= RDW);
            c_wr    = m_active && !acc_rw && (c_k <= WRW);
            c_hold  = m_active && !acc_rw && (c_k == WRW + 1);
            c_valid = m_active && acc_rw  && (c_k == RDW + 1);
            c_busy  = c_rd || c_wr || c_hold;
            check("ready",  32'(ready),  32'(!c_busy));
            check("valid",  32'(valid),  32'(c_valid));
            check("oe_n",   32'(oe_n),   32'(!c_rd));
            check("we_n",   32'(we_n),   32'(!c_wr));
            check("ce_a_n", 32'(ce_a_n), 32'(!c_busy));
            check("ub_a_n", 32'(ub_a_n), 32'(c_busy ? !acc_be[1] : 1'b1));
            check("lb_a_n", 32'(lb_a_n), 32'(c_busy ? !acc_be[0] : 1'b1));
            check("ad",     32'(ad),     32'(last_ad));
            check("data_s2f_r", 32'(data_s2f_r), 32'(exp_rdata));
            if (c_wr || c_hold)  check("bus_wdata", 32'(dio_a), 32'(acc_data));
            else if (c_rd)       check("bus_rdata", 32'(dio_a), 32'(acc_rdata));
            else                 check_released("bus_idle", dio_a);
        end
    end

    // ---------------- stimulus helpers ------------------------------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!m_ready() && n < 20) begin
            tick();
            n++;
        end
        check("wait_ready_in_budget", 32'(n < 20), 32'd1);
    endtask

    // Returns in cycle 1 of the access.
    task automatic issue(input bit r, input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] b);
        rw = r; addr = a; data_f2s = d; be = b; mem = 1'b1;
        tick();
        mem = 1'b0;
    endtask

    task automatic read_expect(input logic [AW-1:0] a, input logic [15:0] exp);
        int n = 1;
        wait_ready();
        issue(1'b1, a, 16'h0000, BE_ALL);
        while (!valid && n < 20) begin
            tick();
            n++;
        end
        check("rd_latency", 32'(n), 32'(RDW + 1));
        check("rd_data",    32'(data_s2f_r), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int falls0;
        int n;
        int oe_low;

        // Reset
        repeat (3) tick();
        check("rst_ready",  32'(ready),  32'd1);
        check("rst_valid",  32'(valid),  32'd0);
        check("rst_data",   32'(data_s2f_r), 32'd0);
        check("rst_ad",     32'(ad), 32'd0);
        check("rst_strobes", 32'({we_n, oe_n, ce_a_n, ub_a_n, lb_a_n}), 32'h1F);
        check("rst_ready2", 32'(ready2), 32'd1);
        check_released("rst_bus", dio_a);
        reset_n = 1'b1;
        tick();

        // Directed write: lower lane only
        wait_ready();
        issue(1'b0, 18'h00012, 16'h00A5, BE_LO);
        check("w_lb_a_n",  32'(lb_a_n), 32'd0);
        check("w_ub_a_n",  32'(ub_a_n), 32'd1);
        check("w_we_c1",   32'(we_n), 32'd0);
        check("w_bus_c1",  32'(dio_a), 32'h00A5);
        tick();
        check("w_we_c2",   32'(we_n), 32'd0);
        check("w_bus_c2",  32'(dio_a), 32'h00A5);
        check("w_ready_c2", 32'(ready), 32'd0);
        tick();
        check("w_we_c3",   32'(we_n), 32'd1);
        check("w_bus_c3",  32'(dio_a), 32'h00A5);
        tick();
        check("w_ready_c4", 32'(ready), 32'd1);

        // Read-back issued in the first ready cycle
        issue(1'b1, 18'h00012, 16'h0000, BE_ALL);
        check("r_oe_c1",    32'(oe_n), 32'd0);
        tick();
        check("r_oe_c2",    32'(oe_n), 32'd0);
        check("r_valid_c2", 32'(valid), 32'd0);
        tick();
        check("r_valid_c3", 32'(valid), 32'd1);
        check("r_data_c3",  32'(data_s2f_r), 32'h00A5);
        check("r_oe_c3",    32'(oe_n), 32'd1);

        // Request during a busy write is dropped
        wait_ready();
        falls0 = we_falls;
        issue(1'b0, 18'h00020, 16'h1111, BE_ALL);
        tick();
        rw = 1'b0; addr = 18'h00021; data_f2s = 16'h2222; be = BE_ALL; mem = 1'b1;
        tick();
        mem = 1'b0;
        wait_ready();
        tick();
        check("busy_one_write", 32'(we_falls - falls0), 32'd1);
        read_expect(18'h00021, 16'h0000);
        read_expect(18'h00020, 16'h1111);

        // Randomised traffic over a small address window
        for (int i = 0; i < 1500; i++) begin
            mem      = ($urandom_range(0, 3) != 0);
            rw       = 1'($urandom_range(0, 1));
            addr     = AW'($urandom_range(0, 15));
            data_f2s = 16'($urandom);
            be       = 2'($urandom_range(0, 3));
            tick();
        end
        mem = 1'b0;
        wait_ready();
        tick();

        // Second instance: RD_WAIT=4, WR_WAIT=1
        rw = 1'b0; addr = 18'h00005; data_f2s = 16'hABCD; be = BE_ALL; mem2 = 1'b1;
        tick();
        mem2 = 1'b0;
        check("p_we_c1",    32'(we2), 32'd0);
        check("p_bus_c1",   32'(dio_b), 32'hABCD);
        check("p_lanes_c1", 32'({ub2, lb2}), 32'd0);
        check("p_ad_c1",    32'(ad2), 32'h5);
        tick();
        check("p_we_c2",    32'(we2), 32'd1);
        check("p_bus_c2",   32'(dio_b), 32'hABCD);
        check("p_ready_c2", 32'(ready2), 32'd0);
        tick();
        check("p_ready_c3", 32'(ready2), 32'd1);
        rw = 1'b1; mem2 = 1'b1;
        tick();
        mem2 = 1'b0;
        n = 1;
        oe_low = 0;
        while (!valid2 && n < 20) begin
            if (!oe2) oe_low++;
            tick();
            n++;
        end
        check("p_rd_latency", 32'(n), 32'd5);
        check("p_oe_cycles",  32'(oe_low), 32'd4);
        check("p_rd_data",    32'(data2), 32'(PAT2));

        // Reset asserted in cycle 1 of a read
        wait_ready();
        issue(1'b1, 18'h00003, 16'h0000, BE_ALL);
        check("mr_oe_before", 32'(oe_n), 32'd0);
        reset_n = 1'b0;
        #1;
        check("mr_oe_async", 32'(oe_n), 32'd1);
        check("mr_ce_async", 32'(ce_a_n), 32'd1);
        check("mr_ready_async", 32'(ready), 32'd1);
        repeat (3) tick();
        reset_n = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (valid) n++;
        end
        check("mr_no_valid", 32'(n), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
